// File: rtl/led_scan_decoder.sv
// rtl/led_scan_decoder.sv - receive-side decoder for the scanned 6-digit 7-segment display bus
//
// Purpose: watches the multiplexed digit enables, segments and decimal point.
// Each digit dwell is deglitched before sampling. Samples are inverted from
// 7-segment to BCD and gathered into a frame. Complete frames are committed to
// double-buffered outputs, together with binary hour/min/sec. A watchdog
// flags loss of scan activity.
//
// Ports:
//   clk          in   1   system clock
//   rst          in   1   synchronous reset, active-high
//   i_seg_enb    in   6   digit enables, active-low one-cold (bit 0 = sec ones)
//   i_seg        in   7   segments {a,b,c,d,e,f,g}, active-high
//   i_seg_dp     in   1   decimal point of the selected digit
//   o_digits     out  24  committed BCD nibbles, [3:0] sec ones .. [23:20] hour tens
//   o_dp         out  6   committed decimal points per digit
//   o_sec        out  6   binary seconds (6'h3F if invalid)
//   o_min        out  6   binary minutes (6'h3F if invalid)
//   o_hou        out  6   binary hours   (6'h3F if invalid)
//   o_frame_vld  out  1   one-cycle pulse per committed frame
//   o_seg_err    out  1   committed frame held an undecodable pattern
//   o_stall      out  1   scan activity lost
module led_scan_decoder #(
    parameter int STABLE_CNT = 4,
    parameter int TIMEOUT    = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  i_seg_enb,
    input  logic [6:0]  i_seg,
    input  logic        i_seg_dp,
    output logic [23:0] o_digits,
    output logic [5:0]  o_dp,
    output logic [5:0]  o_sec,
    output logic [5:0]  o_min,
    output logic [5:0]  o_hou,
    output logic        o_frame_vld,
    output logic        o_seg_err,
    output logic        o_stall
);

    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] C_STB_LAST = SW'(STABLE_CNT - 1);
    localparam logic [SW-1:0] C_STB_FIRE = SW'(STABLE_CNT - 2);
    localparam logic [TW-1:0] C_TO       = TW'(TIMEOUT);

    // input stage and its one-cycle-delayed copy for the stability compare
    logic [5:0]    r_enb, r_enb_p;
    logic [6:0]    r_seg, r_seg_p;
    logic          r_dp, r_dp_p;
    logic [SW-1:0] r_stable;
    logic [TW-1:0] r_to;
    logic [23:0]   r_work;
    logic [5:0]    r_work_dp;
    logic [5:0]    r_mask;
    logic          r_acc;

    logic [5:0]    w_sel;
    logic          w_valid;
    logic          w_same;
    logic          w_sample;
    logic          w_commit;
    logic          w_timeout;
    logic [3:0]    w_nib;
    logic          w_bad;
    logic [5:0]    w_mask_base;
    logic          w_acc_base;

    function automatic logic [5:0] to_bin(input logic [3:0] tens, input logic [3:0] ones);
        logic [6:0] v;
        v = 7'(tens) * 7'd10 + 7'(ones);
        if (tens == 4'hF || ones == 4'hF || v > 7'd63)
            return 6'h3F;
        return v[5:0];
    endfunction

    assign w_sel   = ~r_enb;
    // exactly one enable low: non-zero and a power of two
    assign w_valid = (w_sel != 6'd0) && ((w_sel & (w_sel - 6'd1)) == 6'd0);
    assign w_same  = ({r_enb, r_seg, r_dp} == {r_enb_p, r_seg_p, r_dp_p});
    // fires once per dwell: the counter saturates at STABLE_CNT-1 so this
    // compare cannot match again until the inputs change
    assign w_sample  = w_valid && w_same && (r_stable == C_STB_FIRE);
    // mask becomes full on the cycle after the completing sample
    assign w_commit  = (r_mask == 6'h3F);
    assign w_timeout = (r_to == C_TO);

    // commit or timeout drop the current frame; a same-cycle sample then
    // seeds the next frame
    assign w_mask_base = (w_commit || w_timeout) ? 6'd0 : r_mask;
    assign w_acc_base  = (w_commit || w_timeout) ? 1'b0 : r_acc;

    always_comb begin
        w_nib = 4'hF;
        w_bad = 1'b0;
        case (r_seg)
            7'h7E: w_nib = 4'd0;
            7'h30: w_nib = 4'd1;
            7'h6D: w_nib = 4'd2;
            7'h79: w_nib = 4'd3;
            7'h33: w_nib = 4'd4;
            7'h5B: w_nib = 4'd5;
            7'h5F: w_nib = 4'd6;
            7'h70: w_nib = 4'd7;
            7'h7F: w_nib = 4'd8;
            7'h73: w_nib = 4'd9;
            default: begin
                w_nib = 4'hF;
                w_bad = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_enb       <= 6'h3F;
            r_seg       <= 7'd0;
            r_dp        <= 1'b0;
            r_enb_p     <= 6'h3F;
            r_seg_p     <= 7'd0;
            r_dp_p      <= 1'b0;
            r_stable    <= '0;
            r_to        <= '0;
            r_work      <= 24'd0;
            r_work_dp   <= 6'd0;
            r_mask      <= 6'd0;
            r_acc       <= 1'b0;
            o_digits    <= 24'd0;
            o_dp        <= 6'd0;
            o_sec       <= 6'd0;
            o_min       <= 6'd0;
            o_hou       <= 6'd0;
            o_frame_vld <= 1'b0;
            o_seg_err   <= 1'b0;
            o_stall     <= 1'b0;
        end else begin
            r_enb   <= i_seg_enb;
            r_seg   <= i_seg;
            r_dp    <= i_seg_dp;
            r_enb_p <= r_enb;
            r_seg_p <= r_seg;
            r_dp_p  <= r_dp;

            if (!w_valid || !w_same)
                r_stable <= '0;
            else if (r_stable != C_STB_LAST)
                r_stable <= r_stable + 1'b1;

            if (w_sample)
                r_to <= '0;
            else if (!w_timeout)
                r_to <= r_to + 1'b1;

            if (w_sample)
                o_stall <= 1'b0;
            else if (w_timeout)
                o_stall <= 1'b1;

            for (int k = 0; k < 6; k++) begin
                if (w_sample && w_sel[k]) begin
                    r_work[4*k +: 4] <= w_nib;
                    r_work_dp[k]     <= r_dp;
                end
            end

            r_mask <= w_sample ? (w_mask_base | w_sel) : w_mask_base;
            r_acc  <= w_acc_base | (w_sample & w_bad);

            o_frame_vld <= w_commit;
            if (w_commit) begin
                o_digits  <= r_work;
                o_dp      <= r_work_dp;
                o_sec     <= to_bin(r_work[7:4],   r_work[3:0]);
                o_min     <= to_bin(r_work[15:12], r_work[11:8]);
                o_hou     <= to_bin(r_work[23:20], r_work[19:16]);
                o_seg_err <= r_acc;
            end
        end
    end

endmodule

// File: tb/tb_led_scan_decoder.sv
// tb/tb_led_scan_decoder.sv - directed bench for led_scan_decoder
module tb_led_scan_decoder;

    localparam int TO = 20000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  i_seg_enb;
    logic [6:0]  i_seg;
    logic        i_seg_dp;
    logic [23:0] o_digits;
    logic [5:0]  o_dp;
    logic [5:0]  o_sec;
    logic [5:0]  o_min;
    logic [5:0]  o_hou;
    logic        o_frame_vld;
    logic        o_seg_err;
    logic        o_stall;

    int vectors     = 0;
    int miscompares = 0;
    int frame_cnt   = 0;
    int f0;

    always #5 clk = ~clk;

    led_scan_decoder #(.STABLE_CNT(4), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_seg_enb   (i_seg_enb),
        .i_seg       (i_seg),
        .i_seg_dp    (i_seg_dp),
        .o_digits    (o_digits),
        .o_dp        (o_dp),
        .o_sec       (o_sec),
        .o_min       (o_min),
        .o_hou       (o_hou),
        .o_frame_vld (o_frame_vld),
        .o_seg_err   (o_seg_err),
        .o_stall     (o_stall)
    );

    always @(negedge clk) begin
        if (o_frame_vld === 1'b1)
            frame_cnt++;
    end

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: return 7'h7E;
            4'd1: return 7'h30;
            4'd2: return 7'h6D;
            4'd3: return 7'h79;
            4'd4: return 7'h33;
            4'd5: return 7'h5B;
            4'd6: return 7'h5F;
            4'd7: return 7'h70;
            4'd8: return 7'h7F;
            4'd9: return 7'h73;
            default: return 7'h00;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int k, input logic [6:0] pat, input logic dp, input int dwell);
        logic [5:0] one;
        one       = 6'd1;
        i_seg_enb = ~(one << k);
        i_seg     = pat;
        i_seg_dp  = dp;
        repeat (dwell) tick();
    endtask

    task automatic idle(input int n);
        i_seg_enb = 6'h3F;
        i_seg     = 7'h00;
        i_seg_dp  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic scan(input logic [23:0] bcd, input logic [5:0] dps, input int first, input int last);
        for (int k = first; k <= last; k++)
            put(k, enc(bcd[4*k +: 4]), dps[k], 10);
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset with random inputs
        rst       = 1'b1;
        i_seg_enb = 6'($urandom);
        i_seg     = 7'($urandom);
        i_seg_dp  = 1'($urandom);
        tick();
        i_seg_enb = 6'($urandom);
        i_seg     = 7'($urandom);
        tick();
        chk("rst_digits", o_digits, 24'h0);
        chk("rst_hou",    o_hou,    24'd0);
        chk("rst_min",    o_min,    24'd0);
        chk("rst_sec",    o_sec,    24'd0);
        chk("rst_dp",     o_dp,     24'd0);
        chk("rst_flags",  {o_frame_vld, o_seg_err, o_stall}, 24'd0);
        rst = 1'b0;
        idle(3);
        chk("rst_nofrm",  frame_cnt, 24'd0);

        // clean frame 12:34:56 with dp on digits 2 and 4
        f0 = frame_cnt;
        scan(24'h123456, 6'b010100, 0, 5);
        idle(5);
        chk("t2_frames", frame_cnt - f0, 24'd1);
        chk("t2_digits", o_digits, 24'h123456);
        chk("t2_hou",    o_hou,    24'd12);
        chk("t2_min",    o_min,    24'd34);
        chk("t2_sec",    o_sec,    24'd56);
        chk("t2_err",    o_seg_err, 24'd0);
        chk("t2_dp",     o_dp,     24'h14);

        // digit2 dwell too short, then completed later: 21:07:38
        f0 = frame_cnt;
        scan(24'h210738, 6'd0, 0, 1);
        put(2, enc(4'd7), 1'b0, 2);
        scan(24'h210738, 6'd0, 3, 5);
        idle(5);
        chk("t3_nofrm",  frame_cnt - f0, 24'd0);
        chk("t3_hold",   o_digits, 24'h123456);
        put(2, enc(4'd7), 1'b0, 10);
        idle(5);
        chk("t3_frames", frame_cnt - f0, 24'd1);
        chk("t3_digits", o_digits, 24'h210738);
        chk("t3_hou",    o_hou,    24'd21);
        chk("t3_min",    o_min,    24'd7);
        chk("t3_sec",    o_sec,    24'd38);
        chk("t3_dp",     o_dp,     24'd0);

        // undecodable pattern on digit3
        f0 = frame_cnt;
        scan(24'h123456, 6'd0, 0, 2);
        put(3, 7'h01, 1'b0, 10);
        scan(24'h123456, 6'd0, 4, 5);
        idle(5);
        chk("t4_frames", frame_cnt - f0, 24'd1);
        chk("t4_digits", o_digits, 24'h12F456);
        chk("t4_min",    o_min,    24'h3F);
        chk("t4_hou",    o_hou,    24'd12);
        chk("t4_err",    o_seg_err, 24'd1);
        scan(24'h123456, 6'd0, 0, 5);
        idle(5);
        chk("t4_frames2", frame_cnt - f0, 24'd2);
        chk("t4_err_clr", o_seg_err, 24'd0);
        chk("t4_digits2", o_digits, 24'h123456);

        // scan loss after 3 digits, then full rescan of 09:45:30
        f0 = frame_cnt;
        scan(24'h094530, 6'd0, 0, 2);
        chk("t5_prestall", o_stall, 24'd0);
        idle(TO + 10);
        chk("t5_stall",  o_stall,  24'd1);
        chk("t5_hold",   o_digits, 24'h123456);
        chk("t5_nofrm",  frame_cnt - f0, 24'd0);
        put(0, enc(4'd0), 1'b0, 2);
        chk("t5_stall_early", o_stall, 24'd1);
        put(0, enc(4'd0), 1'b0, 4);
        chk("t5_stall_clr", o_stall, 24'd0);
        put(0, enc(4'd0), 1'b0, 4);
        scan(24'h094530, 6'd0, 1, 5);
        idle(5);
        chk("t5_frames", frame_cnt - f0, 24'd1);
        chk("t5_digits", o_digits, 24'h094530);
        chk("t5_hou",    o_hou,    24'd9);
        chk("t5_min",    o_min,    24'd45);
        chk("t5_sec",    o_sec,    24'd30);
        chk("t5_stall_end", o_stall, 24'd0);

        // reset mid-frame, then full scan of 23:59:59
        scan(24'h111111, 6'd0, 0, 3);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("t6_rst_digits", o_digits, 24'h0);
        chk("t6_rst_hou",    o_hou,    24'd0);
        f0 = frame_cnt;
        scan(24'h235959, 6'd0, 0, 5);
        idle(5);
        chk("t6_frames", frame_cnt - f0, 24'd1);
        chk("t6_digits", o_digits, 24'h235959);
        chk("t6_hou",    o_hou,    24'd23);
        chk("t6_min",    o_min,    24'd59);
        chk("t6_sec",    o_sec,    24'd59);

        // binary range boundary: 64 saturates, 63 passes
        f0 = frame_cnt;
        scan(24'h646309, 6'd0, 0, 5);
        idle(5);
        chk("t7_frames", frame_cnt - f0, 24'd1);
        chk("t7_hou",    o_hou,    24'h3F);
        chk("t7_min",    o_min,    24'd63);
        chk("t7_sec",    o_sec,    24'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
